mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between instruction fetch (IF) and the data-memory stage (DM) of MIPS_DLX.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_timeout.sv | 29 ++
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/DM unified-memory port arbiter.
// State encoding and default widths are common to the RTL and the bench.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_STARVE_MAX = 4;
    localparam int unsigned DEF_TIMEOUT    = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Busy-cycle watchdog: counts cycles without mem_ready and flags expiry.
// Expiry is combinational so the abort lands on the TIMEOUT-th idle cycle.
module arb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expire_c
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    assign o_expire_c = i_count && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count && !o_expire_c) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data memory,
// with DM priority, an IF starvation guard and a busy-cycle timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_t        r_state, w_state_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_if_ack, w_if_ack_nxt;
    logic              r_dm_ack, w_dm_ack_nxt;
    logic              r_bus_err, w_bus_err_nxt;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
    logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_nxt;
    logic [SW-1:0]     r_starve_cnt, w_starve_nxt;
    logic              w_busy;
    logic              w_expire;
    logic              w_if_forced;

    assign w_busy      = (r_state == ST_BUSY_IF) || (r_state == ST_BUSY_DM);
    assign w_if_forced = if_req && (r_starve_cnt == SW'(STARVE_MAX));

    // Counter sits at zero outside BUSY, so every BUSY entry starts fresh.
    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (!w_busy),
        .i_count    (w_busy && !mem_ready),
        .o_expire_c (w_expire)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_bus_err    <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_dm_ack     <= w_dm_ack_nxt;
            r_bus_err    <= w_bus_err_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_dm_rdata   <= w_dm_rdata_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_ack_nxt    = 1'b0;
        w_dm_ack_nxt    = 1'b0;
        w_bus_err_nxt   = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_starve_nxt    = r_starve_cnt;

        case (r_state)
            ST_IDLE: begin
                if (dm_req && !w_if_forced) begin
                    w_state_nxt     = ST_BUSY_DM;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = dm_we;
                    w_mem_addr_nxt  = dm_addr;
                    w_mem_wdata_nxt = dm_wdata;
                    // A contested DM win can only happen below the limit.
                    if (if_req && (r_starve_cnt != SW'(STARVE_MAX))) begin
                        w_starve_nxt = r_starve_cnt + SW'(1);
                    end
                end else if (if_req) begin
                    w_state_nxt     = ST_BUSY_IF;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = if_addr;
                    w_mem_wdata_nxt = '0;
                    w_starve_nxt    = '0;
                end
            end
            ST_BUSY_IF: begin
                if (mem_ready) begin
                    w_state_nxt    = ST_RESP;
                    w_mem_req_nxt  = 1'b0;
                    w_if_ack_nxt   = 1'b1;
                    w_if_rdata_nxt = mem_rdata;
                end else if (w_expire) begin
                    w_state_nxt    = ST_RESP;
                    w_mem_req_nxt  = 1'b0;
                    w_if_ack_nxt   = 1'b1;
                    w_bus_err_nxt  = 1'b1;
                    w_if_rdata_nxt = '0;
                end
            end
            ST_BUSY_DM: begin
                if (mem_ready) begin
                    w_state_nxt   = ST_RESP;
                    w_mem_req_nxt = 1'b0;
                    w_dm_ack_nxt  = 1'b1;
                    if (!r_mem_we) begin
                        w_dm_rdata_nxt = mem_rdata;
                    end
                end else if (w_expire) begin
                    w_state_nxt    = ST_RESP;
                    w_mem_req_nxt  = 1'b0;
                    w_dm_ack_nxt   = 1'b1;
                    w_bus_err_nxt  = 1'b1;
                    w_dm_rdata_nxt = '0;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign bus_err   = r_bus_err;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

    // Stalls fall with reset so the pipeline sees a clean state immediately.
    assign if_stall  = reset && if_req && !r_if_ack;
    assign dm_stall  = reset && dm_req && !r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-programmable memory model
// plus one task per scenario, each with its own inline checks.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        dm_stall;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;

    // memory model state
    int          lat      = 0;
    logic [31:0] rdata_val = '0;
    int          busy_cnt = 0;
    int          last_len = 0;
    int          n_grants = 0;
    int          const_err = 0;
    logic [31:0] g_addr  [64];
    logic [31:0] g_wdata [64];
    logic        g_we    [64];

    mem_port_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .dm_stall  (dm_stall),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: ready is asserted in the lat-th cycle of an access, counted from 0.
    always @(negedge clock) begin
        if (!reset || !mem_req) begin
            if (busy_cnt != 0) last_len = busy_cnt;
            busy_cnt  = 0;
            mem_ready = 1'b0;
        end else begin
            if (busy_cnt == 0) begin
                if (n_grants < 64) begin
                    g_addr[n_grants]  = mem_addr;
                    g_wdata[n_grants] = mem_wdata;
                    g_we[n_grants]    = mem_we;
                end
                n_grants++;
            end else if (n_grants > 0 && n_grants <= 64) begin
                if (mem_addr !== g_addr[n_grants-1] || mem_we !== g_we[n_grants-1] ||
                    mem_wdata !== g_wdata[n_grants-1]) const_err++;
            end
            mem_ready = (busy_cnt == lat);
            mem_rdata = rdata_val;
            busy_cnt++;
        end
    end

    task automatic wait_ack(input int budget, output int cyc, output logic got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < budget) begin
            @(posedge clock);
            #1;
            cyc++;
            if (if_ack || dm_ack) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        #3 reset = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        total++; if ({if_ack, dm_ack, bus_err} !== 3'b000) begin bad++; $display("FAIL reset_acks got=%b exp=000", {if_ack, dm_ack, bus_err}); end
        total++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, dm_rdata); end
        total++; if (mem_addr !== 32'h0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_addr got=%h/%b exp=0/0", mem_addr, mem_we); end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
    endtask

    task automatic test_if_read;
        int cyc; logic got; int g0;
        g0 = n_grants;
        lat = 2; rdata_val = 32'h2002_0005;
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL if_stall_wait got=%b exp=1", if_stall); end
        wait_ack(20, cyc, got);
        total++; if (!got || cyc != 4) begin bad++; $display("FAIL if_latency got=%0d exp=4", cyc); end
        total++; if (if_ack !== 1'b1 || dm_ack !== 1'b0) begin bad++; $display("FAIL if_ack_sel got=%b%b exp=10", if_ack, dm_ack); end
        total++; if (if_rdata !== 32'h2002_0005) begin bad++; $display("FAIL if_rdata got=%h exp=20020005", if_rdata); end
        total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL if_stall_ack got=%b exp=0", if_stall); end
        total++; if (n_grants != g0 + 1 || g_addr[g0] !== 32'h40 || g_we[g0] !== 1'b0) begin
            bad++; $display("FAIL if_mem_cmd got=%h/%b exp=00000040/0", g_addr[g0], g_we[g0]); end
        if_req = 1'b0;
        @(posedge clock); #1;
        total++; if (if_ack !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL if_ack_pulse got=%b/%b exp=0/0", if_ack, mem_req); end
    endtask

    task automatic test_priority;
        int cyc; logic got; int g0;
        g0 = n_grants;
        lat = 0; rdata_val = 32'h1111_2222;
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        wait_ack(20, cyc, got);
        total++; if (!got || dm_ack !== 1'b1 || if_ack !== 1'b0 || cyc != 2) begin
            bad++; $display("FAIL prio_dm_first got=%b%b cyc=%0d exp=01 cyc=2", if_ack, dm_ack, cyc); end
        total++; if (g_addr[g0] !== 32'h100 || g_we[g0] !== 1'b1 || g_wdata[g0] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL prio_dm_cmd got=%h/%b/%h exp=00000100/1/deadbeef", g_addr[g0], g_we[g0], g_wdata[g0]); end
        total++; if (dm_rdata !== 32'h0) begin bad++; $display("FAIL write_keeps_rdata got=%h exp=0", dm_rdata); end
        dm_req = 1'b0;
        wait_ack(20, cyc, got);
        total++; if (!got || if_ack !== 1'b1 || cyc != 3) begin bad++; $display("FAIL prio_if_next got=%b cyc=%0d exp=1 cyc=3", if_ack, cyc); end
        total++; if (if_rdata !== 32'h1111_2222 || g_addr[g0+1] !== 32'h80 || g_we[g0+1] !== 1'b0) begin
            bad++; $display("FAIL prio_if_data got=%h/%h exp=11112222/00000080", if_rdata, g_addr[g0+1]); end
        if_req = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_starve;
        int cyc; logic got;
        lat = 0; rdata_val = 32'hA5A5_0001;
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        for (int i = 0; i < 5; i++) begin
            wait_ack(20, cyc, got);
            total++; if (!got || dm_ack !== (i < 4) || if_ack !== (i == 4)) begin
                bad++; $display("FAIL starve_seq_%0d got=%b%b exp=%b%b", i, if_ack, dm_ack, (i == 4), (i < 4)); end
            if (i == 3) begin
                total++; if (dut.r_starve_cnt !== 3'd4) begin bad++; $display("FAIL starve_sat got=%0d exp=4", dut.r_starve_cnt); end
                total++; if (dm_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL starve_dm_rdata got=%h exp=a5a50001", dm_rdata); end
            end
        end
        total++; if (dut.r_starve_cnt !== 3'd0) begin bad++; $display("FAIL starve_clear got=%0d exp=0", dut.r_starve_cnt); end
        if_req = 1'b0;
        wait_ack(20, cyc, got);
        total++; if (!got || dm_ack !== 1'b1) begin bad++; $display("FAIL starve_dm_resume got=%b exp=1", dm_ack); end
        dm_req = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_timeout;
        int cyc; logic got;
        lat = 1000;
        @(negedge clock);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
        wait_ack(40, cyc, got);
        total++; if (!got || cyc != 16) begin bad++; $display("FAIL tmo_latency got=%0d exp=16", cyc); end
        total++; if (dm_ack !== 1'b1 || bus_err !== 1'b1 || dm_rdata !== 32'h0) begin
            bad++; $display("FAIL tmo_resp got=%b/%b/%h exp=1/1/0", dm_ack, bus_err, dm_rdata); end
        dm_req = 1'b0;
        @(posedge clock); #1;
        total++; if (last_len != 15) begin bad++; $display("FAIL tmo_req_len got=%0d exp=15", last_len); end
        total++; if (bus_err !== 1'b0 || dm_ack !== 1'b0 || dut.r_state !== ST_IDLE) begin
            bad++; $display("FAIL tmo_pulse got=%b/%b/%0d exp=0/0/0", bus_err, dm_ack, dut.r_state); end
    endtask

    task automatic test_async_reset;
        int cyc; logic got; int g0;
        lat = 1000;
        @(negedge clock);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
        repeat (3) @(posedge clock);
        #3;
        if_req = 1'b1; if_addr = 32'h700;
        total++; if (mem_req !== 1'b1 || dut.r_state !== ST_BUSY_DM) begin bad++; $display("FAIL arst_pre got=%b exp=1", mem_req); end
        reset = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || if_ack !== 1'b0 || dm_ack !== 1'b0) begin
            bad++; $display("FAIL arst_out got=%b%b%b exp=000", mem_req, if_ack, dm_ack); end
        total++; if (if_stall !== 1'b0 || dm_stall !== 1'b0) begin bad++; $display("FAIL arst_stall got=%b%b exp=00", if_stall, dm_stall); end
        dm_req = 1'b0;
        lat = 1; rdata_val = 32'h1234_5678;
        @(negedge clock) reset = 1'b1;
        g0 = n_grants;
        wait_ack(20, cyc, got);
        total++; if (!got || if_ack !== 1'b1 || cyc != 3) begin bad++; $display("FAIL arst_if_serve got=%b cyc=%0d exp=1 cyc=3", if_ack, cyc); end
        total++; if (if_rdata !== 32'h1234_5678 || g_addr[g0] !== 32'h700) begin
            bad++; $display("FAIL arst_if_data got=%h/%h exp=12345678/00000700", if_rdata, g_addr[g0]); end
        if_req = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_hold_resp;
        int cyc; logic got; int g0;
        g0 = n_grants;
        lat = 0; rdata_val = 32'h5555_AAAA;
        @(negedge clock);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
        wait_ack(20, cyc, got);
        total++; if (!got || dm_ack !== 1'b1 || cyc != 2 || mem_req !== 1'b0) begin
            bad++; $display("FAIL hold_first got=%b cyc=%0d req=%b exp=1 cyc=2 req=0", dm_ack, cyc, mem_req); end
        @(posedge clock); #1;
        dm_we = 1'b1; dm_addr = 32'h504; dm_wdata = 32'hCAFE_0000;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hold_no_reserve got=%b exp=0", mem_req); end
        wait_ack(20, cyc, got);
        total++; if (!got || dm_ack !== 1'b1 || cyc != 2) begin bad++; $display("FAIL hold_new_req got=%b cyc=%0d exp=1 cyc=2", dm_ack, cyc); end
        total++; if (n_grants != g0 + 2 || g_addr[g0+1] !== 32'h504 || g_we[g0+1] !== 1'b1) begin
            bad++; $display("FAIL hold_grants got=%0d/%h exp=%0d/00000504", n_grants - g0, g_addr[g0+1], 2); end
        total++; if (dm_rdata !== 32'h5555_AAAA) begin bad++; $display("FAIL hold_wr_rdata got=%h exp=5555aaaa", dm_rdata); end
        dm_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++; if (n_grants != g0 + 2 || mem_req !== 1'b0) begin bad++; $display("FAIL hold_quiet got=%0d exp=2", n_grants - g0); end
        total++; if (const_err != 0) begin bad++; $display("FAIL mem_cmd_stable got=%0d exp=0", const_err); end
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        test_reset();
        test_if_read();
        test_priority();
        test_starve();
        test_timeout();
        test_async_reset();
        test_hold_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
